// File: rtl/piano_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : piano_voice_allocator
//  Description : Reads press/release event pairs from the UART RX FIFO,
//                assigns key characters to voice slots and echoes presses.
//  Revision    : 1.0 - initial release
// ============================================================================
module piano_voice_allocator #(
    parameter int         NUM_VOICES = 4,
    parameter logic [7:0] ID_PRESS   = 8'h80,
    parameter logic [7:0] ID_RELEASE = 8'h81
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              ua_rx_dout,
    input  logic                    ua_rx_empty,
    output logic                    ua_rx_rd_en,
    output logic [7:0]              ua_tx_din,
    output logic                    ua_tx_wr_en,
    input  logic                    ua_tx_full,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic [8*NUM_VOICES-1:0] voice_addr,
    output logic [2:0]              steal_ptr
);

    localparam logic [2:0] c_last_slot = 3'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_ID = 3'd1,
        S_DEC_ID  = 3'd2,
        S_RD_CHR  = 3'd3,
        S_WAIT_CH = 3'd4,
        S_APPLY   = 3'd5,
        S_ECHO    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_rd_en;
    logic                    w_rd_en_nxt;
    logic                    r_mode_press;
    logic                    w_mode_nxt;
    logic [7:0]              r_char;
    logic [NUM_VOICES-1:0]   r_voice_active;
    logic [NUM_VOICES-1:0]   w_active_nxt;
    logic [8*NUM_VOICES-1:0] r_voice_addr;
    logic [8*NUM_VOICES-1:0] w_addr_nxt;
    logic [2:0]              r_steal_ptr;
    logic [2:0]              w_steal_nxt;
    logic [NUM_VOICES-1:0]   w_hit;
    logic [NUM_VOICES-1:0]   w_free_sel;
    logic                    w_any_free;

    // Registered read strobe: the FIFO pops at the end of the pulse cycle,
    // so dout is valid in DEC_ID / APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rd_en      <= 1'b0;
            r_mode_press <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_mode_press <= w_mode_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en_nxt = 1'b0;
        w_mode_nxt  = r_mode_press;
        case (r_state)
            S_IDLE: begin
                if (!ua_rx_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = S_WAIT_ID;
                end
            end
            S_WAIT_ID: w_state_nxt = S_DEC_ID;
            S_DEC_ID: begin
                if (ua_rx_dout == ID_PRESS) begin
                    w_mode_nxt  = 1'b1;
                    w_state_nxt = S_RD_CHR;
                end else if (ua_rx_dout == ID_RELEASE) begin
                    w_mode_nxt  = 1'b0;
                    w_state_nxt = S_RD_CHR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_CHR: begin
                if (!ua_rx_empty) begin
                    w_rd_en_nxt = 1'b1;
                    w_state_nxt = S_WAIT_CH;
                end
            end
            S_WAIT_CH: w_state_nxt = S_APPLY;
            S_APPLY:   w_state_nxt = r_mode_press ? S_ECHO : S_IDLE;
            S_ECHO: begin
                if (!ua_tx_full) w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_slot
            assign w_hit[v] = r_voice_active[v] && (r_voice_addr[8*v +: 8] == ua_rx_dout);
        end
    endgenerate

    always_comb begin
        w_active_nxt = r_voice_active;
        w_addr_nxt   = r_voice_addr;
        w_steal_nxt  = r_steal_ptr;
        w_free_sel   = '0;
        w_any_free   = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!r_voice_active[v] && !w_any_free) begin
                w_free_sel[v] = 1'b1;
                w_any_free    = 1'b1;
            end
        end
        if (r_state == S_APPLY) begin
            if (r_mode_press) begin
                // A key already sounding keeps its slot; otherwise fill or steal.
                if (w_hit == '0) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (w_any_free ? w_free_sel[v] : (3'(v) == r_steal_ptr)) begin
                            w_active_nxt[v]        = 1'b1;
                            w_addr_nxt[8*v +: 8]   = ua_rx_dout;
                        end
                    end
                    if (!w_any_free) begin
                        w_steal_nxt = (r_steal_ptr == c_last_slot) ? 3'd0 : r_steal_ptr + 3'd1;
                    end
                end
            end else begin
                w_active_nxt = r_voice_active & ~w_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_voice_active <= '0;
            r_voice_addr   <= '0;
            r_steal_ptr    <= 3'd0;
            r_char         <= 8'd0;
        end else begin
            r_voice_active <= w_active_nxt;
            r_voice_addr   <= w_addr_nxt;
            r_steal_ptr    <= w_steal_nxt;
            if (r_state == S_APPLY) r_char <= ua_rx_dout;
        end
    end

    assign ua_rx_rd_en  = r_rd_en;
    assign ua_tx_din    = r_char;
    assign ua_tx_wr_en  = (r_state == S_ECHO) && !ua_tx_full;
    assign voice_active = r_voice_active;
    assign voice_addr   = r_voice_addr;
    assign steal_ptr    = r_steal_ptr;

endmodule
`default_nettype wire

// File: tb/tb_piano_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piano_voice_allocator
//  Description : Directed self-checking bench with RX/TX FIFO models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piano_voice_allocator;

    localparam int NV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    ua_rx_dout = 8'd0;
    logic          ua_rx_empty = 1'b1;
    logic          ua_rx_rd_en;
    logic [7:0]    ua_tx_din;
    logic          ua_tx_wr_en;
    logic          ua_tx_full = 1'b0;
    logic [NV-1:0] voice_active;
    logic [8*NV-1:0] voice_addr;
    logic [2:0]    steal_ptr;

    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int proto_err = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_log[$];

    piano_voice_allocator #(.NUM_VOICES(NV), .ID_PRESS(8'h80), .ID_RELEASE(8'h81)) dut (
        .clk(clk), .rst(rst),
        .ua_rx_dout(ua_rx_dout), .ua_rx_empty(ua_rx_empty), .ua_rx_rd_en(ua_rx_rd_en),
        .ua_tx_din(ua_tx_din), .ua_tx_wr_en(ua_tx_wr_en), .ua_tx_full(ua_tx_full),
        .voice_active(voice_active), .voice_addr(voice_addr), .steal_ptr(steal_ptr)
    );

    always #5 clk = ~clk;

    // RX FIFO model: pop on rd_en, data valid the following cycle.
    always @(posedge clk) begin
        if (ua_rx_rd_en) begin
            if (rx_q.size() == 0) begin
                proto_err++;
            end else begin
                logic [7:0] b;
                b = rx_q.pop_front();
                ua_rx_dout <= b;
            end
            ua_rx_empty <= (rx_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (ua_rx_rd_en) rd_cnt++;
        if (ua_tx_wr_en) begin
            tx_log.push_back(ua_tx_din);
            if (ua_tx_full) proto_err++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        rx_q.push_back(b);
        ua_rx_empty = 1'b0;
    endtask

    task automatic send(input logic [7:0] id, input logic [7:0] ch);
        @(negedge clk);
        push(id);
        push(ch);
    endtask

    task automatic press(input logic [7:0] ch);
        send(8'h80, ch);
        step(10);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ua_tx_full = 1'b0;
        rx_q.delete();
        ua_rx_empty = 1'b1;
        step(2);
        tx_log.delete();
        rd_cnt = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if ({ua_rx_rd_en, ua_tx_wr_en, ua_tx_din} !== 10'd0) begin
            errors++; $display("FAIL reset_strobes: got %h required 000", {ua_rx_rd_en, ua_tx_wr_en, ua_tx_din});
        end
        checks++;
        if ({voice_active, voice_addr, steal_ptr} !== '0) begin
            errors++; $display("FAIL reset_voices: active=%b addr=%h steal=%0d required all 0", voice_active, voice_addr, steal_ptr);
        end
        checks++;
        if (dut.r_state !== 3'd0) begin
            errors++; $display("FAIL reset_state: got %0d required 0", dut.r_state);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        int t_rd[$];
        int t_upd;
        int lat;
        t_upd = -1;
        do_reset();
        send(8'h80, 8'h61);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (ua_rx_rd_en) t_rd.push_back(cyc);
            if (t_upd < 0 && voice_active != '0) t_upd = cyc;
        end
        lat = (t_rd.size() == 2) ? t_upd - t_rd[1] : -99;
        checks++;
        if (t_rd.size() != 2) begin
            errors++; $display("FAIL press_rd_pulses: got %0d required 2", t_rd.size());
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL press_latency: got %0d required 2", lat);
        end
        checks++;
        if (voice_active !== 4'b0001 || voice_addr !== 32'h0000_0061) begin
            errors++; $display("FAIL press_slot0: active=%b addr=%h required 0001 00000061", voice_active, voice_addr);
        end
        checks++;
        if (tx_log.size() != 1 || (tx_log.size() == 1 && tx_log[0] !== 8'h61)) begin
            errors++; $display("FAIL press_echo: writes=%0d required one write of 61", tx_log.size());
        end
    endtask

    task automatic test_steal();
        do_reset();
        press(8'h61); press(8'h62); press(8'h63); press(8'h64);
        checks++;
        if (voice_active !== 4'b1111 || voice_addr !== 32'h6463_6261 || steal_ptr !== 3'd0) begin
            errors++; $display("FAIL fill_all: active=%b addr=%h steal=%0d required 1111 64636261 0", voice_active, voice_addr, steal_ptr);
        end
        press(8'h65);
        checks++;
        if (voice_addr !== 32'h6463_6265 || steal_ptr !== 3'd1) begin
            errors++; $display("FAIL steal_e: addr=%h steal=%0d required 64636265 1", voice_addr, steal_ptr);
        end
        press(8'h66);
        checks++;
        if (voice_addr !== 32'h6463_6665 || steal_ptr !== 3'd2) begin
            errors++; $display("FAIL steal_f: addr=%h steal=%0d required 64636665 2", voice_addr, steal_ptr);
        end
        press(8'h67); press(8'h68);
        checks++;
        if (voice_addr !== 32'h6867_6665 || steal_ptr !== 3'd0 || voice_active !== 4'b1111) begin
            errors++; $display("FAIL steal_wrap: addr=%h steal=%0d active=%b required 68676665 0 1111", voice_addr, steal_ptr, voice_active);
        end
    endtask

    task automatic test_release();
        do_reset();
        press(8'h61);
        tx_log.delete();
        send(8'h81, 8'h61);
        step(10);
        checks++;
        if (voice_active !== 4'b0000 || voice_addr !== 32'h0000_0061) begin
            errors++; $display("FAIL release_a: active=%b addr=%h required 0000 00000061", voice_active, voice_addr);
        end
        checks++;
        if (tx_log.size() != 0) begin
            errors++; $display("FAIL release_no_echo: writes=%0d required 0", tx_log.size());
        end
        send(8'h81, 8'h7a);
        step(10);
        checks++;
        if (voice_active !== 4'b0000 || voice_addr !== 32'h0000_0061 || tx_log.size() != 0) begin
            errors++; $display("FAIL release_z: active=%b addr=%h writes=%0d required 0000 00000061 0", voice_active, voice_addr, tx_log.size());
        end
    endtask

    task automatic test_repeat_and_drop();
        int r0;
        do_reset();
        press(8'h61); press(8'h61);
        checks++;
        if (voice_active !== 4'b0001 || voice_addr !== 32'h0000_0061) begin
            errors++; $display("FAIL repeat_slot: active=%b addr=%h required 0001 00000061", voice_active, voice_addr);
        end
        checks++;
        if (tx_log.size() != 2 || (tx_log.size() == 2 && (tx_log[0] !== 8'h61 || tx_log[1] !== 8'h61))) begin
            errors++; $display("FAIL repeat_echo: writes=%0d required two writes of 61", tx_log.size());
        end
        r0 = rd_cnt;
        @(negedge clk);
        push(8'h55);
        step(3);
        checks++;
        if (dut.r_state !== 3'd0 || rd_cnt - r0 != 1) begin
            errors++; $display("FAIL drop_byte: state=%0d reads=%0d required 0 1", dut.r_state, rd_cnt - r0);
        end
        checks++;
        if (voice_active !== 4'b0001 || voice_addr !== 32'h0000_0061 || tx_log.size() != 2) begin
            errors++; $display("FAIL drop_no_effect: active=%b addr=%h writes=%0d required 0001 00000061 2", voice_active, voice_addr, tx_log.size());
        end
    endtask

    task automatic test_tx_full();
        do_reset();
        ua_tx_full = 1'b1;
        send(8'h80, 8'h71);
        step(12);
        checks++;
        if (dut.r_state !== 3'd6 || tx_log.size() != 0 || ua_tx_wr_en !== 1'b0) begin
            errors++; $display("FAIL full_park: state=%0d writes=%0d wr_en=%b required 6 0 0", dut.r_state, tx_log.size(), ua_tx_wr_en);
        end
        checks++;
        if (voice_active !== 4'b0001 || voice_addr !== 32'h0000_0071) begin
            errors++; $display("FAIL full_voice: active=%b addr=%h required 0001 00000071", voice_active, voice_addr);
        end
        ua_tx_full = 1'b0;
        step(4);
        checks++;
        if (tx_log.size() != 1 || (tx_log.size() == 1 && tx_log[0] !== 8'h71) || dut.r_state !== 3'd0) begin
            errors++; $display("FAIL full_release: writes=%0d state=%0d required one write of 71 and state 0", tx_log.size(), dut.r_state);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        push(8'h80); push(8'h62); push(8'h80); push(8'h63); push(8'h81); push(8'h62);
        step(30);
        checks++;
        if (voice_active !== 4'b0010 || voice_addr !== 32'h0000_6362) begin
            errors++; $display("FAIL b2b_voices: active=%b addr=%h required 0010 00006362", voice_active, voice_addr);
        end
        checks++;
        if (tx_log.size() != 2 || (tx_log.size() == 2 && (tx_log[0] !== 8'h62 || tx_log[1] !== 8'h63))) begin
            errors++; $display("FAIL b2b_echo: writes=%0d required 62 then 63", tx_log.size());
        end
        checks++;
        if (rd_cnt != 6 || proto_err != 0) begin
            errors++; $display("FAIL b2b_reads: reads=%0d proto=%0d required 6 0", rd_cnt, proto_err);
        end
    endtask

    task automatic test_reset_mid_event();
        do_reset();
        send(8'h80, 8'h61);
        step(4);
        checks++;
        if (dut.r_state !== 3'd4 || ua_rx_rd_en !== 1'b1) begin
            errors++; $display("FAIL mid_wait_ch: state=%0d rd_en=%b required 4 1", dut.r_state, ua_rx_rd_en);
        end
        rst = 1'b1;
        step(1);
        checks++;
        if ({ua_rx_rd_en, ua_tx_wr_en, ua_tx_din, voice_active, voice_addr, steal_ptr} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: active=%b addr=%h rd=%b wr=%b required all 0", voice_active, voice_addr, ua_rx_rd_en, ua_tx_wr_en);
        end
        rst = 1'b0;
        step(10);
        checks++;
        if (voice_active !== 4'b0000 || voice_addr !== 32'd0 || tx_log.size() != 0) begin
            errors++; $display("FAIL mid_discard: active=%b addr=%h writes=%0d required 0000 0 0", voice_active, voice_addr, tx_log.size());
        end
        press(8'h62);
        checks++;
        if (voice_active !== 4'b0001 || voice_addr !== 32'h0000_0062 || tx_log.size() != 1) begin
            errors++; $display("FAIL mid_recover: active=%b addr=%h writes=%0d required 0001 00000062 1", voice_active, voice_addr, tx_log.size());
        end
        checks++;
        if (proto_err != 0) begin
            errors++; $display("FAIL protocol: violations=%0d required 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_steal();
        test_release();
        test_repeat_and_drop();
        test_tx_full();
        test_back_to_back();
        test_reset_mid_event();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
